// File: rtl/sprite_draw_scheduler_if.sv
// Drawer-side and framebuffer-side signals of sprite_draw_scheduler.
// The scheduler uses the slave modport; the game top level and the drawers use master.
interface sprite_draw_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  logic                  frame_tick;
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      plot_out;
  logic [N_REQ*10-1:0]   drw_x;
  logic [N_REQ*10-1:0]   drw_y;
  logic [N_REQ*3-1:0]    drw_color;
  logic [N_REQ-1:0]      drw_we;
  logic [N_REQ-1:0]      draw_done;
  logic [9:0]            vga_x;
  logic [9:0]            vga_y;
  logic [2:0]            vga_color;
  logic                  vga_we;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;
  logic [N_REQ-1:0]      timeout_err;

  modport master (
    output frame_tick, req, drw_x, drw_y, drw_color, drw_we, draw_done,
    input  plot_out, vga_x, vga_y, vga_color, vga_we, busy, frame_done, overrun, timeout_err
  );

  modport slave (
    input  frame_tick, req, drw_x, drw_y, drw_color, drw_we, draw_done,
    output plot_out, vga_x, vga_y, vga_color, vga_we, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// Shares the VGA framebuffer write port between N_REQ sprite drawers.
// Each frame_tick starts a schedule that runs every requesting drawer in turn,
// lowest index first, and muxes the granted drawer's pixels to the framebuffer.
// Optional clear-screen sweep before drawing: define CLEAR_SCREEN_EN.
module sprite_draw_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TIMEOUT  = 2048,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input logic                   clk,
  input logic                   reset_n,
  sprite_draw_scheduler_if.slave bus
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef CLEAR_SCREEN_EN
    CLEAR,
`endif
    SCAN,
    START,
    WAIT,
    NEXT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt;
  logic [GW-1:0]    grant, grant_nxt, low_idx;
  logic [N_REQ-1:0] grant_oh;
  logic [CW-1:0]    wait_cnt, wait_cnt_nxt;
  logic [N_REQ-1:0] plot_q, plot_nxt;
  logic [9:0]       vx_q, vx_nxt, vy_q, vy_nxt;
  logic [2:0]       vc_q, vc_nxt;
  logic             vwe_q, vwe_nxt;
  logic             busy_q, busy_nxt;
  logic             fdone_q, fdone_nxt;
  logic             ovr_q, ovr_nxt;
  logic [N_REQ-1:0] terr_q, terr_nxt;

`ifdef CLEAR_SCREEN_EN
  localparam int unsigned XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int unsigned YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  logic [XW-1:0] cx, cx_nxt;
  logic [YW-1:0] cy, cy_nxt;
`endif

  // Degenerate configuration guard: a zero-sized screen has no meaning.
  if (SCREEN_W == 0 || SCREEN_H == 0 || $bits(BG_COLOR) != 3) begin : g_bad_cfg
  end

  // One-hot form of the current grant, used for masking and start pulses.
  assign grant_oh = N_REQ'(1) << grant;

  // Index of the lowest still-pending drawer.
  always_comb begin
    low_idx = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = GW'(i);
    end
  end

  // Next-state and next-output logic for the schedule FSM.
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    grant_nxt    = grant;
    wait_cnt_nxt = wait_cnt;
    plot_nxt     = '0;
    vx_nxt       = vx_q;
    vy_nxt       = vy_q;
    vc_nxt       = vc_q;
    vwe_nxt      = 1'b0;
    fdone_nxt    = 1'b0;
    ovr_nxt      = bus.frame_tick && (state != IDLE);
    terr_nxt     = terr_q;
`ifdef CLEAR_SCREEN_EN
    cx_nxt       = cx;
    cy_nxt       = cy;
`endif
    case (state)
      IDLE: begin
        if (bus.frame_tick) begin
          pending_nxt = bus.req;
`ifdef CLEAR_SCREEN_EN
          cx_nxt    = '0;
          cy_nxt    = '0;
          state_nxt = CLEAR;
`else
          state_nxt = SCAN;
`endif
        end
      end
`ifdef CLEAR_SCREEN_EN
      CLEAR: begin
        vx_nxt  = 10'(cx);
        vy_nxt  = 10'(cy);
        vc_nxt  = BG_COLOR;
        vwe_nxt = 1'b1;
        if (cx == XW'(SCREEN_W - 1)) begin
          cx_nxt = '0;
          if (cy == YW'(SCREEN_H - 1)) state_nxt = SCAN;
          else                         cy_nxt    = cy + YW'(1);
        end else begin
          cx_nxt = cx + XW'(1);
        end
      end
`endif
      SCAN: begin
        if (pending == '0) begin
          state_nxt = DONE;
        end else begin
          grant_nxt    = low_idx;
          wait_cnt_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        plot_nxt  = grant_oh;
        state_nxt = WAIT;
      end
      WAIT: begin
        vx_nxt  = 10'(bus.drw_x >> (10 * int'(grant)));
        vy_nxt  = 10'(bus.drw_y >> (10 * int'(grant)));
        vc_nxt  = 3'(bus.drw_color >> (3 * int'(grant)));
        vwe_nxt = |(bus.drw_we & grant_oh);
        if (|(bus.draw_done & grant_oh)) begin
          state_nxt = NEXT;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          terr_nxt  = terr_q | grant_oh;
          state_nxt = NEXT;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      NEXT: begin
        pending_nxt = pending & ~grant_oh;
        state_nxt   = SCAN;
      end
      DONE: begin
        fdone_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pending  <= '0;
      grant    <= '0;
      wait_cnt <= '0;
      plot_q   <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      vc_q     <= '0;
      vwe_q    <= 1'b0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      ovr_q    <= 1'b0;
      terr_q   <= '0;
`ifdef CLEAR_SCREEN_EN
      cx       <= '0;
      cy       <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      grant    <= grant_nxt;
      wait_cnt <= wait_cnt_nxt;
      plot_q   <= plot_nxt;
      vx_q     <= vx_nxt;
      vy_q     <= vy_nxt;
      vc_q     <= vc_nxt;
      vwe_q    <= vwe_nxt;
      busy_q   <= busy_nxt;
      fdone_q  <= fdone_nxt;
      ovr_q    <= ovr_nxt;
      terr_q   <= terr_nxt;
`ifdef CLEAR_SCREEN_EN
      cx       <= cx_nxt;
      cy       <= cy_nxt;
`endif
    end
  end

  assign bus.plot_out    = plot_q;
  assign bus.vga_x       = vx_q;
  assign bus.vga_y       = vy_q;
  assign bus.vga_color   = vc_q;
  assign bus.vga_we      = vwe_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = fdone_q;
  assign bus.overrun     = ovr_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: randomized drawer behaviour
// checked against a frame-level model of the schedule.
module tb_sprite_draw_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned SH = 2;
  localparam logic [2:0]  BG = 3'b101;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_CLR  = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  sprite_draw_scheduler_if #(.N_REQ(N)) bus ();

  sprite_draw_scheduler #(
    .N_REQ(N), .TIMEOUT(TO), .SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: what the framebuffer port should hold and the sticky errors.
  logic [9:0]   m_vx, m_vy;
  logic [2:0]   m_vc;
  logic [N-1:0] m_terr;
  int           done_at [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_plot"},  32'(bus.plot_out), 0);
    chk({tag, "_vx"},    32'(bus.vga_x), 0);
    chk({tag, "_vy"},    32'(bus.vga_y), 0);
    chk({tag, "_vc"},    32'(bus.vga_color), 0);
    chk({tag, "_we"},    32'(bus.vga_we), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_fdone"}, 32'(bus.frame_done), 0);
    chk({tag, "_ovr"},   32'(bus.overrun), 0);
    chk({tag, "_terr"},  32'(bus.timeout_err), 0);
  endtask

  // One clock edge: inject noise/ticks, predict, clock, compare, re-randomize drawers.
  task automatic edge_chk(input int mode, input int a, input int b, input bit done_g,
                          input bit allow_tick, input bit exp_busy,
                          input logic [N-1:0] exp_plot, input bit exp_fdone);
    logic [N-1:0] oh;
    bit ovr, m_we;
    oh = (mode == M_WAIT) ? (N'(1) << a) : '0;
    bus.draw_done = N'($urandom()) & ~oh;
    if (mode == M_WAIT && done_g) bus.draw_done = bus.draw_done | oh;
    ovr = 1'b0;
    if (allow_tick && $urandom_range(0, 7) == 0) begin
      bus.frame_tick = 1'b1;
      ovr = 1'b1;
    end
    m_we = 1'b0;
    if (mode == M_WAIT) begin
      m_vx = bus.drw_x[10*a +: 10];
      m_vy = bus.drw_y[10*a +: 10];
      m_vc = bus.drw_color[3*a +: 3];
      m_we = bus.drw_we[a];
    end else if (mode == M_CLR) begin
      m_vx = 10'(a);
      m_vy = 10'(b);
      m_vc = BG;
      m_we = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("vga_x",       32'(bus.vga_x), 32'(m_vx));
    chk("vga_y",       32'(bus.vga_y), 32'(m_vy));
    chk("vga_color",   32'(bus.vga_color), 32'(m_vc));
    chk("vga_we",      32'(bus.vga_we), 32'(m_we));
    chk("plot_out",    32'(bus.plot_out), 32'(exp_plot));
    chk("busy",        32'(bus.busy), 32'(exp_busy));
    chk("frame_done",  32'(bus.frame_done), 32'(exp_fdone));
    chk("overrun",     32'(bus.overrun), 32'(ovr));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    bus.frame_tick = 1'b0;
    bus.req        = N'($urandom());
    bus.drw_x      = (N*10)'({$urandom(), $urandom()});
    bus.drw_y      = (N*10)'({$urandom(), $urandom()});
    bus.drw_color  = (N*3)'($urandom());
    bus.drw_we     = N'($urandom());
  endtask

  // A whole frame: optional clear, then each requested drawer in ascending order.
  task automatic run_frame(input logic [N-1:0] r, input bit directed);
    bit dn;
    bus.req        = r;
    bus.frame_tick = 1'b1;
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
`ifdef CLEAR_SCREEN_EN
    for (int p = 0; p < int'(SW * SH); p++)
      edge_chk(M_CLR, p % int'(SW), p / int'(SW), 1'b0, 1'b1, 1'b1, '0, 1'b0);
`endif
    for (int g = 0; g < int'(N); g++) begin
      if (r[g]) begin
        edge_chk(M_IDLE, 0, 0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
        edge_chk(M_IDLE, 0, 0, 1'b0, 1'b1, 1'b1, N'(1) << g, 1'b0);
        if (directed && g == 0) begin
          bus.drw_x[9:0]     = 10'd5;
          bus.drw_y[9:0]     = 10'd7;
          bus.drw_color[2:0] = 3'b110;
          bus.drw_we[0]      = 1'b1;
        end
        for (int k = 0; k < int'(TO); k++) begin
          dn = (done_at[g] == k);
          if (!dn && k == int'(TO) - 1) m_terr[g] = 1'b1;
          edge_chk(M_WAIT, g, 0, dn, 1'b1, 1'b1, '0, 1'b0);
          if (directed && g == 0 && k == 0) begin
            chk("pix_x",  32'(bus.vga_x), 5);
            chk("pix_y",  32'(bus.vga_y), 7);
            chk("pix_c",  32'(bus.vga_color), 6);
            chk("pix_we", 32'(bus.vga_we), 1);
          end
          if (dn) break;
        end
        edge_chk(M_IDLE, 0, 0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      end
    end
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.frame_tick = 1'b0;
    bus.req        = '0;
    bus.drw_x      = '0;
    bus.drw_y      = '0;
    bus.drw_color  = '0;
    bus.drw_we     = '0;
    bus.draw_done  = '0;
    m_vx = '0; m_vy = '0; m_vc = '0; m_terr = '0;

    // Held in reset with inputs toggling: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      bus.frame_tick = i[0];
      bus.req        = N'($urandom());
      @(posedge clk);
      #1;
      chk_zero("rst");
    end
    bus.frame_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Two drawers, directed pixel from drawer 0.
    done_at = '{3, 99, 2, 99};
    run_frame(4'b0101, 1'b1);

    // Empty frame.
    run_frame(4'b0000, 1'b0);

    // Drawer 1 never finishes.
    done_at = '{99, 99, 99, 99};
    run_frame(4'b0010, 1'b0);

    // Completion on the very last WAIT cycle beats the timeout.
    done_at = '{0, 0, 0, int'(TO) - 1};
    run_frame(4'b1000, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < int'(N); i++) done_at[i] = $urandom_range(0, TO + 3);
      run_frame(N'($urandom()), 1'b0);
    end

    // Reset in the middle of a WAIT.
    done_at = '{99, 99, 99, 99};
    bus.req        = 4'b0001;
    bus.frame_tick = 1'b1;
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    edge_chk(M_WAIT, 0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    edge_chk(M_WAIT, 0, 0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    m_vx = '0; m_vy = '0; m_vc = '0; m_terr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      edge_chk(M_IDLE, 0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    done_at = '{1, 4, 0, 2};
    run_frame(4'b1111, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
